tdc_event_reader: RTL and testbench

- Consumer side of the fine TDC encoder output.
- Accepts a one-cycle event strobe and the encoded fine value, which arrives a fixed number of cycles later.
- Tags each event with a free-running coarse counter value captured at the strobe and aligns it with the late fine value.
- Buffers the combined timestamp words in a small FIFO and presents them on a valid/ready stream to readout logic.

---
 rtl/tdc_event_reader_pkg.sv | 24 ++
 rtl/tdc_sync_fifo.sv | 62 ++++++
 rtl/tdc_event_reader.sv | 149 ++++++++++++++
 tb/tb_tdc_event_reader.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/tdc_event_reader_pkg.sv
// Shared definitions for the TDC event reader: default field widths, word-type
// encodings and out_data field offsets.
package tdc_event_reader_pkg;

  localparam int DEF_FINE_BITS   = 6;
  localparam int DEF_COARSE_BITS = 16;

  typedef enum logic {
    WORD_EVENT  = 1'b0,
    WORD_MARKER = 1'b1
  } word_type_e;

  // Word layout, LSB first: fine | coarse-or-epoch | type.
  localparam int FINE_LSB = 0;

  function automatic int coarse_lsb(input int fine_bits);
    return fine_bits;
  endfunction

  function automatic int type_bit_pos(input int fine_bits, input int coarse_bits);
    return fine_bits + coarse_bits;
  endfunction

endpackage

// File: rtl/tdc_sync_fifo.sv
// Synchronous FIFO with full/empty flags; a push while full is accepted only
// when a pop happens in the same cycle.
module tdc_sync_fifo #(
  parameter int WIDTH = 23,
  parameter int DEPTH = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head_data,
  output logic             empty,
  output logic             full
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic             pop_ok;
  logic             push_ok;

  assign empty     = (count_q == '0);
  assign full      = (count_q == (AW+1)'(DEPTH));
  assign head_data = mem[rd_ptr_q];

  always_comb begin
    pop_ok   = pop && !empty;
    push_ok  = push && (!full || pop_ok);
    wr_ptr_d = push_ok ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = pop_ok  ? rd_ptr_q + 1'b1 : rd_ptr_q;
    count_d  = count_q;
    if (push_ok && !pop_ok) begin
      count_d = count_q + 1'b1;
    end else if (pop_ok && !push_ok) begin
      count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // NOTE: storage is deliberately not reset; the pointers and count define validity.
  always_ff @(posedge clock) begin
    if (push_ok) begin
      mem[wr_ptr_q] <= push_data;
    end
  end

endmodule

// File: rtl/tdc_event_reader.sv
// Tags TDC hits with a coarse count, aligns them with the late fine value and
// streams timestamp words out of a FIFO. Rollover markers: TDC_EVENT_READER_ROLLOVER_EN.
module tdc_event_reader
  import tdc_event_reader_pkg::*;
#(
  parameter int FINE_BITS   = DEF_FINE_BITS,
  parameter int COARSE_BITS = DEF_COARSE_BITS,
  parameter int FINE_LAT    = 2,
  parameter int FIFO_DEPTH  = 8,
  parameter int DROP_BITS   = 8
) (
  input  logic                             clock,
  input  logic                             reset,
  input  logic                             event_strobe,
  input  logic [FINE_BITS-1:0]             value_fine,
  output logic                             out_valid,
  input  logic                             out_ready,
  output logic [COARSE_BITS+FINE_BITS:0]   out_data,
  output logic [DROP_BITS-1:0]             drop_count,
  output logic                             overflow
);

  localparam int WORD_BITS = 1 + COARSE_BITS + FINE_BITS;

  logic [COARSE_BITS-1:0]                coarse_q, coarse_d;
  logic [FINE_LAT-1:0]                   tag_valid_q, tag_valid_d;
  logic [FINE_LAT-1:0][COARSE_BITS-1:0]  tag_coarse_q, tag_coarse_d;
  logic [DROP_BITS-1:0]                  drop_count_q, drop_count_d;
  logic                                  overflow_q, overflow_d;

  logic                 event_push;
  logic [WORD_BITS-1:0] event_word;
  logic                 fifo_push;
  logic [WORD_BITS-1:0] fifo_word;
  logic [WORD_BITS-1:0] fifo_head;
  logic                 fifo_empty;
  logic                 fifo_full;
  logic                 drop;

`ifdef TDC_EVENT_READER_ROLLOVER_EN
  logic [COARSE_BITS-1:0] epoch_q, epoch_d;
  logic [COARSE_BITS-1:0] pend_epoch_q, pend_epoch_d;
  logic                   pending_q, pending_d;
  logic                   wrap;
  logic                   marker_req;
  logic [COARSE_BITS-1:0] marker_epoch;
`endif

  assign event_push = tag_valid_q[FINE_LAT-1];
  assign event_word = {WORD_EVENT, tag_coarse_q[FINE_LAT-1], value_fine};

  // NOTE: next-state logic is combinational with every output defaulted first, so no latches.
  always_comb begin
    coarse_d        = coarse_q + 1'b1;
    tag_valid_d     = '0;
    tag_coarse_d    = '0;
    tag_valid_d[0]  = event_strobe;
    tag_coarse_d[0] = coarse_q;
    for (int i = 1; i < FINE_LAT; i++) begin
      tag_valid_d[i]  = tag_valid_q[i-1];
      tag_coarse_d[i] = tag_coarse_q[i-1];
    end
  end

`ifdef TDC_EVENT_READER_ROLLOVER_EN
  // Events own the FIFO write port; a marker that collides with one waits a cycle.
  always_comb begin
    wrap         = (coarse_q == '1);
    epoch_d      = wrap ? epoch_q + 1'b1 : epoch_q;
    marker_req   = pending_q || wrap;
    marker_epoch = wrap ? epoch_d : pend_epoch_q;
    pending_d    = pending_q;
    pend_epoch_d = pend_epoch_q;
    fifo_push    = 1'b0;
    fifo_word    = event_word;
    if (event_push) begin
      fifo_push    = 1'b1;
      pending_d    = marker_req;
      pend_epoch_d = marker_epoch;
    end else if (marker_req) begin
      fifo_push = 1'b1;
      fifo_word = {WORD_MARKER, marker_epoch, {FINE_BITS{1'b0}}};
      pending_d = 1'b0;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      epoch_q      <= '0;
      pend_epoch_q <= '0;
      pending_q    <= 1'b0;
    end else begin
      epoch_q      <= epoch_d;
      pend_epoch_q <= pend_epoch_d;
      pending_q    <= pending_d;
    end
  end
`else
  assign fifo_push = event_push;
  assign fifo_word = event_word;
`endif

  always_comb begin
    drop         = fifo_push && fifo_full && !(out_valid && out_ready);
    drop_count_d = drop_count_q;
    if (drop && (drop_count_q != '1)) begin
      drop_count_d = drop_count_q + 1'b1;
    end
    overflow_d = overflow_q || drop;
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      coarse_q     <= '0;
      tag_valid_q  <= '0;
      tag_coarse_q <= '0;
      drop_count_q <= '0;
      overflow_q   <= 1'b0;
    end else begin
      coarse_q     <= coarse_d;
      tag_valid_q  <= tag_valid_d;
      tag_coarse_q <= tag_coarse_d;
      drop_count_q <= drop_count_d;
      overflow_q   <= overflow_d;
    end
  end

  tdc_sync_fifo #(
    .WIDTH (WORD_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clock     (clock),
    .reset     (reset),
    .push      (fifo_push),
    .push_data (fifo_word),
    .pop       (out_ready),
    .head_data (fifo_head),
    .empty     (fifo_empty),
    .full      (fifo_full)
  );

  // Head storage is unreset, so mask it while the FIFO is empty.
  assign out_valid  = !fifo_empty;
  assign out_data   = out_valid ? fifo_head : '0;
  assign drop_count = drop_count_q;
  assign overflow   = overflow_q;

endmodule

// File: tb/tb_tdc_event_reader.sv
// Scoreboard bench for tdc_event_reader: the driver models event timing, FIFO
// occupancy and drops; a monitor compares each handshaken word in order.
module tb_tdc_event_reader;

  localparam int FB = 6;
`ifdef TDC_EVENT_READER_ROLLOVER_EN
  localparam int CB = 8;
`else
  localparam int CB = 16;
`endif
  localparam int FL    = 2;
  localparam int DEPTH = 8;
  localparam int DB    = 8;
  localparam int W     = 1 + CB + FB;
  localparam int M     = 1 << CB;

  logic          clock;
  logic          reset;
  logic          event_strobe;
  logic [FB-1:0] value_fine;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  out_data;
  logic [DB-1:0] drop_count;
  logic          overflow;

  tdc_event_reader #(
    .FINE_BITS   (FB),
    .COARSE_BITS (CB),
    .FINE_LAT    (FL),
    .FIFO_DEPTH  (DEPTH),
    .DROP_BITS   (DB)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .event_strobe (event_strobe),
    .value_fine   (value_fine),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_data     (out_data),
    .drop_count   (drop_count),
    .overflow     (overflow)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state: expected words in event order, occupancy, drops.
  logic [W-1:0]  exp_q [$];
  int            occ;
  int            drops;
  bit            ovf;
  int            cyc;
  bit            h_strobe [16];
  logic [CB-1:0] h_coarse [16];
  logic [FB-1:0] h_fine   [16];
  bit            pend;
  int            epoch;
  int            pend_epoch;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    exp_q.delete();
    occ = 0; drops = 0; ovf = 0; cyc = 0;
    pend = 0; epoch = 0; pend_epoch = 0;
    for (int i = 0; i < 16; i++) begin
      h_strobe[i] = 0; h_coarse[i] = '0; h_fine[i] = '0;
    end
  endtask

  task automatic model_push(input logic [W-1:0] word, input bit pop);
    if (occ < DEPTH || pop) begin
      exp_q.push_back(word);
      occ++;
    end else begin
      if (drops < (1 << DB) - 1) drops++;
      ovf = 1;
    end
  endtask

  // Drives one cycle (called at posedge+2), predicts its effect, then checks
  // the registered status after the next edge.
  task automatic step(input bit s, input logic [FB-1:0] f, input bit r);
    int  old;
    bit  ev;
    bit  pop;
    bit  wrap;
    bit  mreq;
    int  mep;
    old = (cyc - FL) & 15;
    ev  = (cyc >= FL) && h_strobe[old];
    event_strobe = s;
    out_ready    = r;
    value_fine   = ev ? h_fine[old] : FB'($urandom);
    pop = r && (occ > 0);
    wrap = 0; mreq = 0; mep = 0;
`ifdef TDC_EVENT_READER_ROLLOVER_EN
    if ((cyc % M) == M - 1) begin
      epoch = (epoch + 1) % M;
      wrap  = 1;
    end
    mreq = pend || wrap;
    mep  = wrap ? epoch : pend_epoch;
`endif
    if (ev) begin
      model_push({1'b0, h_coarse[old], h_fine[old]}, pop);
      if (mreq) begin
        pend = 1; pend_epoch = mep;
      end
    end else if (mreq) begin
      model_push({1'b1, CB'(mep), FB'(0)}, pop);
      pend = 0;
    end
    if (pop) occ--;
    h_strobe[cyc & 15] = s;
    h_coarse[cyc & 15] = CB'(cyc % M);
    h_fine[cyc & 15]   = f;
    cyc++;
    @(posedge clock);
    #2;
    check("out_valid", 64'(out_valid), 64'(occ > 0));
    check("drop_count", 64'(drop_count), 64'(drops));
    check("overflow", 64'(overflow), 64'(ovf));
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_valid"}, 64'(out_valid), 64'd0);
    check({tag, "_data"}, 64'(out_data), 64'd0);
    check({tag, "_drop"}, 64'(drop_count), 64'd0);
    check({tag, "_ovf"}, 64'(overflow), 64'd0);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    event_strobe = 1'b0;
    out_ready = 1'b0;
    #1;
    check_reset_outputs("mid_reset");
    @(posedge clock);
    #2;
    reset = 1'b0;
    model_reset();
  endtask

  // Monitor: every accepted word must match the oldest expected word.
  initial begin
    logic [W-1:0] w;
    forever begin
      @(negedge clock);
      if (!reset && out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_word: got %0h expected none (t=%0t)", out_data, $time);
        end else begin
          w = exp_q.pop_front();
          check("word", 64'(out_data), 64'(w));
        end
      end
    end
  end

  initial begin
    logic [W-1:0] exp_w;
    reset = 1'b1;
    event_strobe = 1'b0;
    out_ready = 1'b0;
    value_fine = '0;
    model_reset();
    #12;
    check_reset_outputs("reset");
    @(posedge clock);
    #2;
    reset = 1'b0;

    // Single event at coarse 100, fine 37: visible FINE_LAT+1 cycles later.
    while (cyc < 100) step(0, '0, 0);
    step(1, 6'd37, 0);
    check("lat_t1", 64'(out_valid), 64'd0);
    step(0, '0, 0);
    check("lat_t2", 64'(out_valid), 64'd0);
    step(0, '0, 0);
    check("lat_t3", 64'(out_valid), 64'd1);
    exp_w = {1'b0, CB'(100), FB'(37)};
    check("first_word", 64'(out_data), 64'(exp_w));
    for (int i = 0; i < 4; i++) step(0, '0, 1);

    // Reset one cycle after a strobe: the in-flight tag must vanish.
    step(1, 6'd5, 1);
    do_reset();
    for (int i = 0; i < 10; i++) step(0, '0, 1);
    do_reset();

    // Back-to-back strobes at coarse 10..13 with fine 1..4.
    while (cyc < 10) step(0, '0, 1);
    for (int i = 0; i < 4; i++) step(1, FB'(i + 1), 1);
    for (int i = 0; i < 6; i++) step(0, '0, 1);

    // Ten strobes into a stalled FIFO: eight held, two dropped.
    for (int i = 0; i < 10; i++) step(1, FB'($urandom), 0);
    for (int i = 0; i < FL + 2; i++) step(0, '0, 0);
    check("fill_drops", 64'(drop_count), 64'd2);

    // Push into a full FIFO in the same cycle as a pop is accepted.
    step(1, FB'($urandom), 0);
    step(0, '0, 0);
    step(0, '0, 1);
    step(0, '0, 0);
    check("full_push_pop_drops", 64'(drop_count), 64'd2);
    for (int i = 0; i < 12; i++) step(0, '0, 1);

    // Randomized traffic: light backpressure, then heavy (drives saturation).
    for (int i = 0; i < 3000; i++)
      step(($urandom % 3) == 0, FB'($urandom), ($urandom % 4) != 0);
    for (int i = 0; i < 2500; i++)
      step(($urandom % 2) == 0, FB'($urandom), ($urandom % 8) == 0);

    for (int i = 0; i < 60 && exp_q.size() > 0; i++) step(0, '0, 1);
    check("drain_empty", 64'(exp_q.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
